data_mem_responder: RTL

//   Multi-cycle data-memory responder: the memory end of the datapath's load/store

---
 rtl/data_mem_responder.sv | 98 +++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data memory: accepts one load/store at a time and answers
// after WAIT+1 edges with a one-cycle ready strobe, read data and an error flag.
`timescale 1ns/1ps
module data_mem_responder #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_read,
    input  logic        req_write,
    output logic [31:0] resp_rdata,
    output logic        resp_ready,
    output logic        resp_err,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e          state_q;
    logic [3:0]      count_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            write_q;
    logic            err_q;
    logic [31:0]     mem [DEPTH];
    logic            req_err;
    logic            access;

    // Range check uses the bits above the index, so an oversized address never wraps.
    always_comb begin
        req_err = (req_read & req_write) | (req_addr[1:0] != 2'b00)
                | (req_addr[31:AW+2] != '0);
    end

    assign access = (state_q == StBusy) && (count_q == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            resp_rdata <= 32'd0;
            resp_ready <= 1'b0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_read | req_write) begin
                        idx_q   <= req_addr[AW+1:2];
                        wdata_q <= req_wdata;
                        write_q <= req_write;
                        err_q   <= req_err;
                        count_q <= 4'(WAIT);
                        busy    <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (count_q != 4'd0) begin
                        count_q <= count_q - 4'd1;
                    end else begin
                        state_q    <= StResp;
                        resp_ready <= 1'b1;
                        resp_err   <= err_q;
                        if (err_q) begin
                            resp_rdata <= 32'd0;
                        end else if (!write_q) begin
                            resp_rdata <= mem[idx_q];
                        end
                    end
                end
                StResp: begin
                    state_q    <= StIdle;
                    resp_ready <= 1'b0;
                    resp_err   <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RAM is not reset; a reset before the access edge drops the pending store.
    always_ff @(posedge clk) begin
        if (access && write_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
